// File: rtl/ms_watchdog_pkg.sv
// ms_watchdog_pkg: shared states, register map, kick keys and register bit positions
package ms_watchdog_pkg;
    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_WARN     = 2'd2,
        ST_BITE     = 2'd3
    } state_e;
    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_TIMEOUT = 3'd2;
    localparam logic [2:0] ADDR_GRACE   = 3'd3;
    localparam logic [2:0] ADDR_KICK    = 3'd4;
    localparam logic [2:0] ADDR_COUNT   = 3'd5;
    localparam logic [15:0] KEY1_DEFAULT = 16'h5A5A;
    localparam logic [15:0] KEY2_DEFAULT = 16'hA5A5;
    localparam int STAT_WARN   = 0;
    localparam int STAT_LOCK   = 1;
    localparam int STAT_STATE  = 2;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_LOCK   = 2;
endpackage

// File: rtl/ms_watchdog_kick_seq.sv
// ms_watchdog_kick_seq: two-key kick sequence detector, one-cycle kick_o on KEY1 then KEY2
module ms_watchdog_kick_seq
    import ms_watchdog_pkg::*;
#(
    parameter logic [15:0] KEY1 = KEY1_DEFAULT,
    parameter logic [15:0] KEY2 = KEY2_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_i,
    input  logic [15:0] data_i,
    output logic        kick_o
);
    logic stage_q, stage_d;

    always_comb begin
        stage_d = wr_i ? (data_i == KEY1) : stage_q;
        kick_o  = wr_i & stage_q & (data_i == KEY2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stage_q <= 1'b0;
        else          stage_q <= stage_d;
    end
endmodule

// File: rtl/ms_watchdog.sv
// ms_watchdog: Avalon-MM millisecond watchdog with warning irq and board reset request
module ms_watchdog
    import ms_watchdog_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_DEFAULT    = 16'd1000,
    parameter logic [15:0] GRACE_DEFAULT      = 16'd100,
    parameter int          RESET_PULSE_CYCLES = 16,
    parameter logic [15:0] KEY1               = KEY1_DEFAULT,
    parameter logic [15:0] KEY2               = KEY2_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ms_tick,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic        wdt_reset_req
);
    localparam int PW = $clog2(RESET_PULSE_CYCLES + 1);

    logic tick_q, tick_evt, kick_evt, wr, set_warn;
    logic warn_q, warn_d, enable_q, enable_d, irq_en_q, irq_en_d, lock_q, lock_d;
    logic [15:0] timeout_q, timeout_d, grace_q, grace_d, cnt_q, cnt_d, rdata_d, status, control;
    logic [PW-1:0] pulse_q, pulse_d;
    state_e state_q, state_d;

    assign wr            = chipselect & ~write_n;
    assign tick_evt      = ms_tick & ~tick_q;
    assign irq           = warn_q & irq_en_q;
    assign wdt_reset_req = |pulse_q;

    ms_watchdog_kick_seq #(.KEY1(KEY1), .KEY2(KEY2)) u_kick (
        .clk    (clk),
        .reset_n(reset_n),
        .wr_i   (wr && address == ADDR_KICK),
        .data_i (writedata),
        .kick_o (kick_evt)
    );

    always_comb begin
        enable_d  = (wr && address == ADDR_CONTROL && !lock_q) ? writedata[CTRL_EN] : enable_q;
        irq_en_d  = (wr && address == ADDR_CONTROL) ? writedata[CTRL_IRQ_EN] : irq_en_q;
        lock_d    = lock_q | (wr && address == ADDR_CONTROL && writedata[CTRL_LOCK]);
        timeout_d = (wr && address == ADDR_TIMEOUT && !lock_q) ? writedata : timeout_q;
        grace_d   = (wr && address == ADDR_GRACE && !lock_q) ? writedata : grace_q;
        warn_d    = set_warn | (warn_q & ~(wr && address == ADDR_STATUS));
        status    = '0;
        status[STAT_WARN]         = warn_q;
        status[STAT_LOCK]         = lock_q;
        status[STAT_STATE +: 2]   = state_q;
        control   = '0;
        control[CTRL_EN]          = enable_q;
        control[CTRL_IRQ_EN]      = irq_en_q;
        control[CTRL_LOCK]        = lock_q;
        rdata_d   = (address == ADDR_STATUS)  ? status :
                    (address == ADDR_CONTROL) ? control :
                    (address == ADDR_TIMEOUT) ? timeout_q :
                    (address == ADDR_GRACE)   ? grace_q :
                    (address == ADDR_COUNT)   ? cnt_q : 16'd0;
    end

    // A zero TIMEOUT/GRACE expires on the first tick thanks to the <= 1 compare.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        set_warn = 1'b0;
        case (state_q)
            ST_DISABLED: begin
                cnt_d = timeout_q;
                if (enable_q) state_d = ST_RUN;
            end
            ST_RUN, ST_WARN: begin
                if (!enable_q) begin
                    state_d = ST_DISABLED;
                    cnt_d   = timeout_q;
                end else if (kick_evt) begin
                    state_d = ST_RUN;
                    cnt_d   = timeout_q;
                end else if (tick_evt && cnt_q <= 16'd1) begin
                    state_d  = (state_q == ST_RUN) ? ST_WARN : ST_BITE;
                    cnt_d    = (state_q == ST_RUN) ? grace_q : cnt_q;
                    set_warn = (state_q == ST_RUN);
                end else if (tick_evt) begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: ;
        endcase
        pulse_d = (state_d == ST_BITE && state_q != ST_BITE) ? PW'(RESET_PULSE_CYCLES)
                                                             : pulse_q - PW'(pulse_q != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q    <= 1'b0;
            state_q   <= ST_DISABLED;
            cnt_q     <= TIMEOUT_DEFAULT;
            readdata  <= '0;
            warn_q    <= 1'b0;
            enable_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            lock_q    <= 1'b0;
            timeout_q <= TIMEOUT_DEFAULT;
            grace_q   <= GRACE_DEFAULT;
            pulse_q   <= '0;
        end else begin
            tick_q    <= ms_tick;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            readdata  <= rdata_d;
            warn_q    <= warn_d;
            enable_q  <= enable_d;
            irq_en_q  <= irq_en_d;
            lock_q    <= lock_d;
            timeout_q <= timeout_d;
            grace_q   <= grace_d;
            pulse_q   <= pulse_d;
        end
    end
endmodule

// File: tb/tb_ms_watchdog.sv
// tb_ms_watchdog: scoreboard bench for ms_watchdog with a behavioural watchdog model
module tb_ms_watchdog;
    localparam logic [15:0] K1 = 16'h5A5A;
    localparam logic [15:0] K2 = 16'hA5A5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ms_tick = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq, wdt_reset_req;

    int n_cmp = 0, n_bad = 0, wcnt = 0;
    int exp_q[$], adr_q[$];

    int m_st, m_cnt, m_to, m_gr;
    bit m_warn, m_en, m_ie, m_lock, m_stage;

    ms_watchdog dut (
        .clk(clk), .reset_n(reset_n), .ms_tick(ms_tick), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq), .wdt_reset_req(wdt_reset_req)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) wcnt <= 0;
        else if (wdt_reset_req) wcnt <= wcnt + 1;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Model states: 0 disabled, 1 counting, 2 warned, 3 bitten.
    function automatic void m_reset();
        m_st = 0; m_to = 1000; m_gr = 100; m_cnt = 1000;
        m_warn = 0; m_en = 0; m_ie = 0; m_lock = 0; m_stage = 0;
    endfunction

    function automatic void m_tick();
        if (m_st == 1) begin
            if (m_cnt <= 1) begin m_st = 2; m_cnt = m_gr; m_warn = 1; end
            else m_cnt--;
        end else if (m_st == 2) begin
            if (m_cnt <= 1) m_st = 3;
            else m_cnt--;
        end
    endfunction

    function automatic void m_write(int a, int d, bit t);
        bit kick = (a == 4) && m_stage && (d[15:0] == K2);
        if (a == 0) m_warn = 0;
        if (m_st == 1 || m_st == 2) begin
            if (kick) begin m_st = 1; m_cnt = m_to; end
            else if (t) m_tick();
        end
        case (a)
            1: begin if (!m_lock) m_en = d[0]; m_ie = d[1]; m_lock = m_lock | d[2]; end
            2: if (!m_lock) m_to = d[15:0];
            3: if (!m_lock) m_gr = d[15:0];
            4: m_stage = (d[15:0] == K1);
            default: ;
        endcase
        if (m_st == 0 && m_en) begin m_st = 1; m_cnt = m_to; end
        else if ((m_st == 1 || m_st == 2) && !m_en) m_st = 0;
    endfunction

    function automatic int m_read(int a);
        case (a)
            0: return (m_st << 2) | (int'(m_lock) << 1) | int'(m_warn);
            1: return (int'(m_lock) << 2) | (int'(m_ie) << 1) | int'(m_en);
            2: return m_to;
            3: return m_gr;
            5: return (m_st == 0) ? m_to : m_cnt;
            default: return 0;
        endcase
    endfunction

    initial begin : monitor
        bit v;
        forever begin
            @(posedge clk);
            v = chipselect & write_n;
            @(negedge clk);
            if (v) begin
                if (exp_q.size() == 0) chk("read_unexpected", 1, 0);
                else chk($sformatf("read_addr%0d", adr_q.pop_front()), readdata, exp_q.pop_front());
            end
        end
    end

    task automatic after_op(int prev);
        if (m_st == 3 && prev != 3) begin
            repeat (22) @(negedge clk);
            chk("wdt_pulse_len", wcnt, 16);
            chk("wdt_after_pulse", wdt_reset_req, 0);
        end
    endtask

    task automatic wr(int a, int d, bit t = 0);
        int prev = m_st;
        @(negedge clk);
        address = a[2:0]; writedata = d[15:0]; chipselect = 1; write_n = 0; ms_tick = t;
        m_write(a, d, t);
        @(negedge clk);
        chipselect = 0; write_n = 1; ms_tick = 0;
        repeat (2) @(negedge clk);
        after_op(prev);
    endtask

    task automatic tick(int len);
        int prev = m_st;
        @(negedge clk);
        ms_tick = 1;
        m_tick();
        repeat (len) @(negedge clk);
        ms_tick = 0;
        repeat (2) @(negedge clk);
        after_op(prev);
    endtask

    task automatic rd(int a);
        @(negedge clk);
        address = a[2:0]; chipselect = 1; write_n = 1;
        exp_q.push_back(m_read(a));
        adr_q.push_back(a);
        chk("irq_pin", irq, int'(m_warn & m_ie));
        chk("wdt_count", wcnt, (m_st == 3) ? 16 : 0);
        @(negedge clk);
        chipselect = 0;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #2 reset_n = 0;
        #1 chk("irq_in_reset", irq, 0);
        chk("wdt_in_reset", wdt_reset_req, 0);
        m_reset();
        repeat (2) @(negedge clk);
        reset_n = 1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        reset_n = 1;
        repeat (2) @(negedge clk);
        for (int a = 0; a < 8; a++) rd(a);
        // warn, clear, bite
        wr(2, 5); wr(3, 3); wr(1, 3);
        repeat (5) tick(1);
        rd(0);
        wr(0, 0); rd(0);
        repeat (3) tick(1);
        rd(0);
        // kick reload and broken sequence
        reset_dut();
        wr(2, 5); wr(1, 1);
        repeat (4) tick(1);
        wr(4, K1); wr(4, K2); rd(5); rd(0);
        wr(4, K1); wr(4, 16'h1234); wr(4, K2);
        tick(1); rd(5); tick(1); rd(5);
        // kick concurrent with tick, then held tick level
        wr(4, K1); wr(4, K2, 1); rd(5);
        tick(10); rd(5);
        // lock behaviour and reset mid-warn
        reset_dut();
        wr(2, 2); wr(3, 50); wr(1, 5); wr(1, 0); wr(2, 9);
        rd(1); rd(2);
        wr(1, 7); rd(1);
        repeat (2) tick(1);
        rd(0); rd(5);
        reset_dut();
        for (int a = 0; a < 6; a++) rd(a);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 9);
            if (m_st == 3) reset_dut();
            if (r < 3) tick($urandom_range(1, 3));
            else if (r < 5) rd($urandom_range(0, 7));
            else begin
                int s = $urandom_range(0, 9);
                int a = (s < 4) ? 4 : (s == 4) ? 1 : (s == 5) ? 2 : (s == 6) ? 3 : (s == 7) ? 0 : (s == 8) ? 5 : 6;
                int d = $urandom_range(0, 65535);
                if (a == 4) begin
                    int k = $urandom_range(0, 2);
                    d = (k == 0) ? int'(K1) : (k == 1) ? int'(K2) : d;
                end else if (a == 1) d = int'($urandom_range(0, 4) != 0) | ($urandom_range(0, 1) << 1) | (($urandom_range(0, 15) == 0) ? 4 : 0);
                else if (a == 2 || a == 3) d = $urandom_range(0, 6);
                wr(a, d, $urandom_range(0, 4) == 0);
            end
        end
        repeat (4) @(negedge clk);
        chk("read_queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ms_watchdog.md
Name: ms_watchdog

Overview:
- Avalon-MM 16-bit slave watchdog that consumes the 1 ms tick from the board's millisecond interval timer.
- Counts milliseconds and raises a warning interrupt when software fails to kick within TIMEOUT ms.
- If no kick arrives within a further GRACE ms, asserts a board reset request.
- Sits on the same CPU bus as the timer, directly downstream of the timer's tick/irq output.

Parameters:
TIMEOUT_DEFAULT, 1000, reset value of TIMEOUT register (ms)
GRACE_DEFAULT, 100, reset value of GRACE register (ms)
RESET_PULSE_CYCLES, 16, clk cycles wdt_reset_req stays high on bite (>=1)
KEY1, 16'h5A5A, first kick key
KEY2, 16'hA5A5, second kick key

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
ms_tick  in  1  tick from ms timer; level or pulse, rising edges counted
address  in  3  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  16  write data
readdata  out  16  registered read data
irq  out  1  warning interrupt
wdt_reset_req  out  1  board reset request

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=DISABLED; counter=TIMEOUT_DEFAULT; readdata=0; irq=0; wdt_reset_req=0.
  - warn_flag=0; enable=0; irq_en=0; lock=0; key_stage=0; tick_d=0.
- Tick detection: tick_d registers ms_tick; tick_evt = ms_tick & ~tick_d. One event per rising edge, so the timer's level irq can connect directly.
- Register map (address: read / write):
  - 0 STATUS: read {12'b0, state[1:0], lock, warn_flag}; any write clears warn_flag.
  - 1 CONTROL: bit0 enable, bit1 irq_en, bit2 lock. lock is set-only and cleared only by reset. While locked, writes to enable are ignored; irq_en stays writable.
  - 2 TIMEOUT: 16-bit. Write ignored while locked. Takes effect at next reload only.
  - 3 GRACE: 16-bit. Same rules as TIMEOUT.
  - 4 KICK: write-only, reads 0. Key sequence below.
  - 5 COUNT: read-only current counter.
  - 6,7: read 0, writes ignored.
- Read latency: 1 clk (readdata registered every cycle from a combinational mux). Reads have no side effects.
- Kick sequence:
  - A write of KEY1 to KICK sets key_stage=1.
  - A write of KEY2 to KICK while key_stage=1 produces kick_evt (1 cycle) and sets key_stage=0.
  - Any other KICK write sets key_stage=0, except a KEY1 write, which sets key_stage=1.
  - Writes to other addresses do not affect key_stage.
- States (2-bit encoding):
  - DISABLED=0: counter held at TIMEOUT. enable becoming 1 -> RUN with counter=TIMEOUT.
  - RUN=1:
    - kick_evt -> counter=TIMEOUT.
    - Else on tick_evt: if counter<=1 -> WARN, counter=GRACE, warn_flag=1; otherwise counter-1.
    - TIMEOUT=0 behaves as 1.
  - WARN=2:
    - kick_evt -> RUN, counter=TIMEOUT; warn_flag stays set.
    - Else on tick_evt: if counter<=1 -> BITE; otherwise counter-1.
    - GRACE=0 behaves as 1.
  - BITE=3:
    - wdt_reset_req=1 for exactly RESET_PULSE_CYCLES clks starting the cycle after entry, then 0.
    - Stays in BITE until reset_n. Kicks, enable and STATUS writes have no effect on state.
- enable cleared (unlocked) in RUN or WARN -> DISABLED next cycle; warn_flag unchanged.
- Same-cycle kick_evt and tick_evt: kick wins; counter reloads with no decrement.
- Same-cycle STATUS write and a warn_flag set event: the set wins.
- irq = warn_flag & irq_en (combinational from registers).
- Counter is 16-bit unsigned and never decrements below 1 within a state; no wrap.

Decomposition:
- Shared package: state enum (DISABLED/RUN/WARN/BITE), register address constants 0-5, KEY1/KEY2 defaults, STATUS/CONTROL bit positions.
- One natural sub-module: ms_watchdog_kick_seq (key_stage register + compare; inputs wr strobe and writedata, output kick_evt).
- Tick edge detect, FSM, register file and read mux stay in the top module.

Test Plan:
- Reset, then read addresses 0-5 -> STATUS=0, CONTROL=0, TIMEOUT=1000, GRACE=100, KICK=0, COUNT=1000; irq=0; wdt_reset_req=0.
- TIMEOUT=5, GRACE=3, CONTROL=3, 5 tick rising edges -> STATUS state=WARN, warn_flag=1, irq=1. STATUS write -> irq=0; 3 more ticks -> state=BITE; wdt_reset_req high exactly 16 clks.
- TIMEOUT=5, 4 ticks, KICK 0x5A5A then 0xA5A5 -> COUNT=5, state=RUN. KICK 0x5A5A, 0x1234, 0xA5A5 -> no kick; COUNT keeps decrementing.
- Kick pair's second write in the same clk as a tick rising edge -> COUNT=TIMEOUT, no decrement.
- ms_tick held high 10 clks -> one decrement only.
- CONTROL=5 (enable+lock), then write CONTROL=0 and TIMEOUT=9 -> enable stays 1, TIMEOUT unchanged. Write CONTROL=7 -> irq_en=1. reset_n pulsed mid-WARN -> all reset values, wdt_reset_req=0.
